fetch_seq: RTL and testbench
============================

FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, PC/address/data width.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, return-address stack entries (legal range 1..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  advance enable; 0 = stall, all state holds.
REQ-006 SHALL have port jmp_mode  input  3  flow-control mode for current instruction.
REQ-007 SHALL have port flag_z  input  1  ALU zero flag for conditional modes.
REQ-008 SHALL have port jmp_addr  input  WIDTH  absolute target / offset operand.
REQ-009 SHALL have port base_reg_ld  input  1  load base register.
REQ-010 SHALL have port base_reg_data  input  WIDTH  base register load value.
REQ-011 SHALL have port pc_out  output  WIDTH  current program counter (instruction ROM address).
REQ-012 SHALL have port ret_addr  output  WIDTH  top-of-stack value; 0 when empty.
REQ-013 SHALL have port sp_cnt  output  5  number of valid stack entries.
REQ-014 SHALL have ports stack_full, stack_empty  output  1 each  stack status, combinational from sp_cnt.
REQ-015 SHALL have ports err_ovf, err_unf  output  1 each  sticky overflow/underflow flags.
REQ-016 SHALL have port halted  output  1  sticky halt indicator.
REQ-017 SHALL have port taken  output  1  registered; 1 for one cycle after any non-sequential PC update.

Function
REQ-018 SHALL decode jmp_mode: 000 NEXT, 001 JMP, 010 JZ, 011 JNZ, 100 JBASE, 101 CALL, 110 RET, 111 HALT.
REQ-019 NEXT SHALL set pc_out <= pc_out+1, modulo 2^WIDTH (FF..F wraps to 0).
REQ-020 JMP SHALL set pc_out <= jmp_addr.
REQ-021 JZ SHALL set pc_out <= jmp_addr if flag_z=1, else pc_out+1; JNZ inverse condition.
REQ-022 JBASE SHALL set pc_out <= base + jmp_addr modulo 2^WIDTH; base = base_reg_data if base_reg_ld=1 same cycle (bypass), else stored base register.
REQ-023 base register SHALL load base_reg_data on clk when en=1 and base_reg_ld=1, independent of jmp_mode.
REQ-024 CALL with stack not full SHALL push pc_out+1 (wrapped), sp_cnt+1, pc_out <= jmp_addr.
REQ-025 CALL with stack full SHALL behave as NEXT, leave stack unchanged, set err_ovf.
REQ-026 RET with stack not empty SHALL set pc_out <= ret_addr, pop, sp_cnt-1.
REQ-027 RET with stack empty SHALL behave as NEXT and set err_unf.
REQ-028 HALT SHALL hold pc_out and set halted; while halted, all modes ignored, pc_out, stack, base hold.
REQ-029 taken SHALL be 1 in the cycle after a JMP, taken JZ/JNZ, JBASE, successful CALL or successful RET; 0 otherwise, including stall, HALT, error fall-through.
REQ-030 en=0 SHALL freeze pc_out, stack, sp_cnt, base register, flags, and force taken <= 0.
REQ-031 stack SHALL be LIFO; ret_addr SHALL reflect the most recent unpopped push combinationally.
REQ-032 err_ovf, err_unf, halted SHALL clear only by reset.

Reset
REQ-033 rst=0 SHALL immediately force pc_out=0, sp_cnt=0, base=0, ret_addr=0, err_ovf=0, err_unf=0, halted=0, taken=0, regardless of clk or en.
REQ-034 reset asserted mid-CALL/RET SHALL discard the operation; first update after release uses mode at that edge.

Verification
REQ-035 Reset release, en=1, NEXT x3 -> pc_out 0,1,2,3; taken=0 throughout.
REQ-036 WIDTH=8, pc=FE, NEXT x2 -> pc FF then 00; JZ addr=40, flag_z=0 -> pc+1; flag_z=1 -> 40, taken=1 next cycle.
REQ-037 STACK_DEPTH=4: CALL 10,20,30,40 from pc 5 -> sp_cnt=4, stack_full=1; fifth CALL -> pc+1, err_ovf=1; RET x4 -> return addresses in reverse push order; RET on empty -> err_unf=1, pc+1.
REQ-038 base_reg_ld=1 data=80 with JBASE offset=05 same cycle -> pc=85; later JBASE offset=F0 -> pc=70 (wrap).
REQ-039 CALL with en=0 for 3 cycles -> no state change; HALT -> halted=1, pc holds under any mode until rst=0 pulse asynchronously clears all to 0.

Source files
------------

// File: rtl/fetch_seq_if.sv
// Control/status bundle between an instruction sequencer and its driver.
// The sequencer uses the slave modport; the controller side uses master.
interface fetch_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic [2:0]       jmp_mode;
    logic             flag_z;
    logic [WIDTH-1:0] jmp_addr;
    logic             base_reg_ld;
    logic [WIDTH-1:0] base_reg_data;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] ret_addr;
    logic [4:0]       sp_cnt;
    logic             stack_full;
    logic             stack_empty;
    logic             err_ovf;
    logic             err_unf;
    logic             halted;
    logic             taken;

    modport master (
        output en, jmp_mode, flag_z, jmp_addr, base_reg_ld, base_reg_data,
        input  pc_out, ret_addr, sp_cnt, stack_full, stack_empty, err_ovf, err_unf,
        input  halted, taken
    );

    modport slave (
        input  en, jmp_mode, flag_z, jmp_addr, base_reg_ld, base_reg_data,
        output pc_out, ret_addr, sp_cnt, stack_full, stack_empty, err_ovf, err_unf,
        output halted, taken
    );
endinterface

// File: rtl/fetch_seq.sv
// Program counter sequencer: jumps, conditional branches, base-relative jumps,
// call/return through a small LIFO, and a sticky halt.
module fetch_seq #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    fetch_seq_if.slave   bus
);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    localparam int unsigned IdxW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [4:0]  SpFull = 5'(STACK_DEPTH);

    localparam logic [2:0] ModeNext  = 3'b000;
    localparam logic [2:0] ModeJmp   = 3'b001;
    localparam logic [2:0] ModeJz    = 3'b010;
    localparam logic [2:0] ModeJnz   = 3'b011;
    localparam logic [2:0] ModeJbase = 3'b100;
    localparam logic [2:0] ModeCall  = 3'b101;
    localparam logic [2:0] ModeRet   = 3'b110;
    localparam logic [2:0] ModeHalt  = 3'b111;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [WIDTH-1:0] stack_d [STACK_DEPTH];
    logic [4:0]       sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             taken_q, taken_d;

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] base_eff;
    logic [WIDTH-1:0] top_val;
    logic [IdxW-1:0]  top_idx;
    logic [IdxW-1:0]  push_idx;
    logic             full;
    logic             empty;
    logic             advance;

    assign pc_inc   = pc_q + WIDTH'(1);
    assign base_eff = bus.base_reg_ld ? bus.base_reg_data : base_q;
    assign full     = (sp_q == SpFull);
    assign empty    = (sp_q == 5'd0);
    assign top_idx  = IdxW'(sp_q - 5'd1);
    assign push_idx = IdxW'(sp_q);
    assign top_val  = empty ? '0 : stack_q[top_idx];
    assign advance  = bus.en && (state_q == StRun);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
            pc_q    <= '0;
            base_q  <= '0;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            taken_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            base_q  <= base_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            taken_q <= taken_d;
            stack_q <= stack_d;
        end
    end

    // Halt is terminal until reset
    always_comb begin
        state_d = state_q;
        if (advance && bus.jmp_mode == ModeHalt) begin
            state_d = StHalt;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        base_d  = base_q;
        sp_d    = sp_q;
        stack_d = stack_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        taken_d = 1'b0;
        if (advance) begin
            if (bus.base_reg_ld) begin
                base_d = bus.base_reg_data;
            end
            case (bus.jmp_mode)
                ModeNext: pc_d = pc_inc;
                ModeJmp: begin
                    pc_d    = bus.jmp_addr;
                    taken_d = 1'b1;
                end
                ModeJz: begin
                    pc_d    = bus.flag_z ? bus.jmp_addr : pc_inc;
                    taken_d = bus.flag_z;
                end
                ModeJnz: begin
                    pc_d    = bus.flag_z ? pc_inc : bus.jmp_addr;
                    taken_d = !bus.flag_z;
                end
                ModeJbase: begin
                    pc_d    = base_eff + bus.jmp_addr;
                    taken_d = 1'b1;
                end
                ModeCall: begin
                    if (!full) begin
                        stack_d[push_idx] = pc_inc;
                        sp_d              = sp_q + 5'd1;
                        pc_d              = bus.jmp_addr;
                        taken_d           = 1'b1;
                    end else begin
                        pc_d  = pc_inc;
                        ovf_d = 1'b1;
                    end
                end
                ModeRet: begin
                    if (!empty) begin
                        pc_d    = top_val;
                        sp_d    = sp_q - 5'd1;
                        taken_d = 1'b1;
                    end else begin
                        pc_d  = pc_inc;
                        unf_d = 1'b1;
                    end
                end
                ModeHalt: pc_d = pc_q;
            endcase
        end
    end

    always_comb begin
        bus.halted      = (state_q == StHalt);
        bus.pc_out      = pc_q;
        bus.ret_addr    = top_val;
        bus.sp_cnt      = sp_q;
        bus.stack_full  = full;
        bus.stack_empty = empty;
        bus.err_ovf     = ovf_q;
        bus.err_unf     = unf_q;
        bus.taken       = taken_q;
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: the driver queues the hand-computed state expected
// after each clock edge, and a monitor checks it one time unit after that edge.
module tb_fetch_seq;

    localparam logic [2:0] NEXT = 3'b000, JMP = 3'b001, JZ = 3'b010, JNZ = 3'b011;
    localparam logic [2:0] JBASE = 3'b100, CALL = 3'b101, RET = 3'b110, HALT = 3'b111;

    typedef struct {
        int         id;
        logic [7:0] pc;
        logic [4:0] sp;
        logic [7:0] ret;
        logic       tk;
        logic [2:0] fl;  // {halted, err_unf, err_ovf}
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   vec_id = 0;
    exp_t exp_q[$];

    fetch_seq_if #(.WIDTH(8)) bus ();

    fetch_seq #(.WIDTH(8), .STACK_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id, input logic [31:0] act,
                       input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s #%0d: got %0h expected %0h", nm, id, act, want);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".pc"},     0, 32'(bus.pc_out),      32'h0);
        chk({tag, ".sp"},     0, 32'(bus.sp_cnt),      32'h0);
        chk({tag, ".ret"},    0, 32'(bus.ret_addr),    32'h0);
        chk({tag, ".taken"},  0, 32'(bus.taken),       32'h0);
        chk({tag, ".ovf"},    0, 32'(bus.err_ovf),     32'h0);
        chk({tag, ".unf"},    0, 32'(bus.err_unf),     32'h0);
        chk({tag, ".halted"}, 0, 32'(bus.halted),      32'h0);
        chk({tag, ".empty"},  0, 32'(bus.stack_empty), 32'h1);
        chk({tag, ".full"},   0, 32'(bus.stack_full),  32'h0);
    endtask

    task automatic drive(input logic e, input logic [2:0] m, input logic fz,
                         input logic [7:0] a, input logic bl, input logic [7:0] bd);
        bus.en            = e;
        bus.jmp_mode      = m;
        bus.flag_z        = fz;
        bus.jmp_addr      = a;
        bus.base_reg_ld   = bl;
        bus.base_reg_data = bd;
    endtask

    // Called at a negedge: apply inputs, queue the expected post-edge state.
    task automatic step(input logic e, input logic [2:0] m, input logic fz,
                        input logic [7:0] a, input logic bl, input logic [7:0] bd,
                        input logic [7:0] xpc, input logic [4:0] xsp,
                        input logic [7:0] xret, input logic xtk, input logic [2:0] xfl);
        exp_t x;
        drive(e, m, fz, a, bl, bd);
        vec_id++;
        x.id = vec_id; x.pc = xpc; x.sp = xsp; x.ret = xret; x.tk = xtk; x.fl = xfl;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                chk("pc_out",      x.id, 32'(bus.pc_out),      32'(x.pc));
                chk("sp_cnt",      x.id, 32'(bus.sp_cnt),      32'(x.sp));
                chk("ret_addr",    x.id, 32'(bus.ret_addr),    32'(x.ret));
                chk("taken",       x.id, 32'(bus.taken),       32'(x.tk));
                chk("err_ovf",     x.id, 32'(bus.err_ovf),     32'(x.fl[0]));
                chk("err_unf",     x.id, 32'(bus.err_unf),     32'(x.fl[1]));
                chk("halted",      x.id, 32'(bus.halted),      32'(x.fl[2]));
                chk("stack_full",  x.id, 32'(bus.stack_full),  32'(x.sp == 5'd4));
                chk("stack_empty", x.id, 32'(bus.stack_empty), 32'(x.sp == 5'd0));
            end
        end
    end

    initial begin : driver
        drive(1'b1, CALL, 1'b0, 8'h33, 1'b1, 8'h44);
        #3;
        chk_reset("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        //   en  mode   fz    addr   bl    data     pc     sp     ret    tk    {h,u,o}
        step(1, NEXT,  1'b0, 8'h00, 1'b0, 8'h00,   8'h01, 5'd0, 8'h00, 1'b0, 3'b000);
        step(1, NEXT,  1'b0, 8'h00, 1'b0, 8'h00,   8'h02, 5'd0, 8'h00, 1'b0, 3'b000);
        step(1, NEXT,  1'b0, 8'h00, 1'b0, 8'h00,   8'h03, 5'd0, 8'h00, 1'b0, 3'b000);
        step(1, JMP,   1'b0, 8'hFE, 1'b0, 8'h00,   8'hFE, 5'd0, 8'h00, 1'b1, 3'b000);
        step(1, NEXT,  1'b0, 8'h00, 1'b0, 8'h00,   8'hFF, 5'd0, 8'h00, 1'b0, 3'b000);
        step(1, NEXT,  1'b0, 8'h00, 1'b0, 8'h00,   8'h00, 5'd0, 8'h00, 1'b0, 3'b000);
        step(1, JZ,    1'b0, 8'h40, 1'b0, 8'h00,   8'h01, 5'd0, 8'h00, 1'b0, 3'b000);
        step(1, JZ,    1'b1, 8'h40, 1'b0, 8'h00,   8'h40, 5'd0, 8'h00, 1'b1, 3'b000);
        step(1, JNZ,   1'b1, 8'h10, 1'b0, 8'h00,   8'h41, 5'd0, 8'h00, 1'b0, 3'b000);
        step(1, JNZ,   1'b0, 8'h10, 1'b0, 8'h00,   8'h10, 5'd0, 8'h00, 1'b1, 3'b000);
        // Base register bypass, wrap and mode-independent load
        step(1, JBASE, 1'b0, 8'h05, 1'b1, 8'h80,   8'h85, 5'd0, 8'h00, 1'b1, 3'b000);
        step(1, NEXT,  1'b0, 8'h00, 1'b0, 8'h00,   8'h86, 5'd0, 8'h00, 1'b0, 3'b000);
        step(1, JBASE, 1'b0, 8'hF0, 1'b0, 8'h00,   8'h70, 5'd0, 8'h00, 1'b1, 3'b000);
        step(1, NEXT,  1'b0, 8'h00, 1'b1, 8'h20,   8'h71, 5'd0, 8'h00, 1'b0, 3'b000);
        step(1, JBASE, 1'b0, 8'h03, 1'b0, 8'h00,   8'h23, 5'd0, 8'h00, 1'b1, 3'b000);
        // Fill the stack, overflow, drain in LIFO order, underflow
        step(1, JMP,   1'b0, 8'h05, 1'b0, 8'h00,   8'h05, 5'd0, 8'h00, 1'b1, 3'b000);
        step(1, CALL,  1'b0, 8'h10, 1'b0, 8'h00,   8'h10, 5'd1, 8'h06, 1'b1, 3'b000);
        step(1, CALL,  1'b0, 8'h20, 1'b0, 8'h00,   8'h20, 5'd2, 8'h11, 1'b1, 3'b000);
        step(1, CALL,  1'b0, 8'h30, 1'b0, 8'h00,   8'h30, 5'd3, 8'h21, 1'b1, 3'b000);
        step(1, CALL,  1'b0, 8'h40, 1'b0, 8'h00,   8'h40, 5'd4, 8'h31, 1'b1, 3'b000);
        step(1, CALL,  1'b0, 8'h50, 1'b0, 8'h00,   8'h41, 5'd4, 8'h31, 1'b0, 3'b001);
        step(1, RET,   1'b0, 8'h00, 1'b0, 8'h00,   8'h31, 5'd3, 8'h21, 1'b1, 3'b001);
        step(1, RET,   1'b0, 8'h00, 1'b0, 8'h00,   8'h21, 5'd2, 8'h11, 1'b1, 3'b001);
        step(1, RET,   1'b0, 8'h00, 1'b0, 8'h00,   8'h11, 5'd1, 8'h06, 1'b1, 3'b001);
        step(1, RET,   1'b0, 8'h00, 1'b0, 8'h00,   8'h06, 5'd0, 8'h00, 1'b1, 3'b001);
        step(1, RET,   1'b0, 8'h00, 1'b0, 8'h00,   8'h07, 5'd0, 8'h00, 1'b0, 3'b011);
        // Stall, then halt holds everything
        step(0, CALL,  1'b0, 8'h60, 1'b1, 8'h99,   8'h07, 5'd0, 8'h00, 1'b0, 3'b011);
        step(0, CALL,  1'b0, 8'h60, 1'b1, 8'h99,   8'h07, 5'd0, 8'h00, 1'b0, 3'b011);
        step(0, CALL,  1'b0, 8'h60, 1'b1, 8'h99,   8'h07, 5'd0, 8'h00, 1'b0, 3'b011);
        step(1, CALL,  1'b0, 8'h60, 1'b0, 8'h00,   8'h60, 5'd1, 8'h08, 1'b1, 3'b011);
        step(0, JMP,   1'b0, 8'h77, 1'b0, 8'h00,   8'h60, 5'd1, 8'h08, 1'b0, 3'b011);
        step(1, HALT,  1'b0, 8'h00, 1'b0, 8'h00,   8'h60, 5'd1, 8'h08, 1'b0, 3'b111);
        step(1, JMP,   1'b0, 8'h99, 1'b0, 8'h00,   8'h60, 5'd1, 8'h08, 1'b0, 3'b111);
        step(1, CALL,  1'b0, 8'h10, 1'b0, 8'h00,   8'h60, 5'd1, 8'h08, 1'b0, 3'b111);
        step(1, RET,   1'b0, 8'h00, 1'b0, 8'h00,   8'h60, 5'd1, 8'h08, 1'b0, 3'b111);
        step(1, NEXT,  1'b0, 8'h00, 1'b1, 8'h55,   8'h60, 5'd1, 8'h08, 1'b0, 3'b111);
        // Asynchronous reset mid-cycle with a CALL pending, held across an edge
        drive(1'b1, CALL, 1'b0, 8'h10, 1'b1, 8'h44);
        #2;
        rst = 1'b0;
        #1;
        chk_reset("async");
        @(posedge clk);
        #2;
        chk_reset("held");
        @(negedge clk);
        rst = 1'b1;
        step(1, JBASE, 1'b0, 8'h07, 1'b0, 8'h00,   8'h07, 5'd0, 8'h00, 1'b1, 3'b000);
        step(1, RET,   1'b0, 8'h00, 1'b0, 8'h00,   8'h08, 5'd0, 8'h00, 1'b0, 3'b010);
        @(posedge clk);
        #3;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
